// File: rtl/mac_seq_pkg.sv
// rtl/mac_seq_pkg.sv - shared state encoding and RAM latency for the dot-product sequencer
package mac_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLR   = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_CAP   = 3'd4,
        ST_DONE  = 3'd5
    } seq_state_e;

    // Operand RAM data arrives this many cycles after its address.
    localparam int RAM_RD_LAT = 1;

endpackage

// File: rtl/mac_seq.sv
// rtl/mac_seq.sv - sequencer driving one mac through a programmable-length dot product
module mac_seq
    import mac_seq_pkg::*;
#(
    parameter int WIDTH  = 24,
    parameter int LEN_W  = 8,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_base,
    input  logic [LEN_W-1:0]  i_len,
    input  logic              i_abort,
    output logic              o_ready,
    output logic              o_mac_clr,
    output logic              o_rd_en,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_acc,
    input  logic [WIDTH-1:0]  i_mac,
    output logic [WIDTH-1:0]  o_result,
    output logic              o_valid,
    input  logic              i_out_ready
);

    seq_state_e        state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  k_q, k_d;
    logic              mac_clr_q, mac_clr_d;
    logic              rd_en_q, rd_en_d;
    logic              acc_q, acc_d;
    logic              valid_q, valid_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [WIDTH-1:0]  result_q, result_d;
    logic              last_k;

    assign last_k = (k_q == len_q - LEN_W'(1));

    // Next state, job parameters and the product index k.
    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        len_d   = len_q;
        k_d     = k_q;
        case (state_q)
            ST_IDLE: begin
                if (i_start && !i_abort) begin
                    base_d  = i_base;
                    len_d   = i_len;
                    k_d     = '0;
                    state_d = ST_CLR;
                end
            end
            ST_CLR:   state_d = (len_q == '0) ? ST_CAP : ST_RUN;
            ST_RUN: begin
                if (last_k) begin
                    state_d = ST_DRAIN;
                end else begin
                    k_d = k_q + LEN_W'(1);
                end
            end
            ST_DRAIN: state_d = ST_CAP;
            ST_CAP:   state_d = ST_DONE;
            ST_DONE: begin
                if (i_out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default:  state_d = ST_IDLE;
        endcase
        // Abort overrides everything outside IDLE; the next CLR cleans the mac.
        if (i_abort && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
            k_d     = k_q;
        end
    end

    // Registered outputs are decoded from the next state so they line up with it.
    always_comb begin
        mac_clr_d = (state_d == ST_CLR);
        rd_en_d   = (state_d == ST_RUN);
        // acc trails rd_en by the RAM latency, but drops at once on abort.
        acc_d     = rd_en_q && (state_d != ST_IDLE);
        valid_d   = (state_d == ST_DONE);
        addr_d    = rd_en_d ? (base_d + ADDR_W'(k_d)) : addr_q;
        result_d  = ((state_q == ST_CAP) && !i_abort) ? i_mac : result_q;
    end

    // State and output registers; the mac is held cleared while in reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            base_q    <= '0;
            len_q     <= '0;
            k_q       <= '0;
            mac_clr_q <= 1'b1;
            rd_en_q   <= 1'b0;
            acc_q     <= 1'b0;
            valid_q   <= 1'b0;
            addr_q    <= '0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            base_q    <= base_d;
            len_q     <= len_d;
            k_q       <= k_d;
            mac_clr_q <= mac_clr_d;
            rd_en_q   <= rd_en_d;
            acc_q     <= acc_d;
            valid_q   <= valid_d;
            addr_q    <= addr_d;
            result_q  <= result_d;
        end
    end

    assign o_ready   = (state_q == ST_IDLE);
    assign o_mac_clr = mac_clr_q;
    assign o_rd_en   = rd_en_q;
    assign o_addr    = addr_q;
    assign o_acc     = acc_q;
    assign o_valid   = valid_q;
    assign o_result  = result_q;

endmodule

// File: tb/tb_mac_seq.sv
// tb/tb_mac_seq.sv - self-checking bench for mac_seq with a fixed-point mac and two 1-cycle RAMs
module tb_mac_seq;

    localparam int WIDTH  = 24;
    localparam int LEN_W  = 8;
    localparam int ADDR_W = 10;
    localparam int FRAC   = 20;

    logic              clk = 1'b0;
    logic              rst;
    logic              i_start;
    logic [ADDR_W-1:0] i_base;
    logic [LEN_W-1:0]  i_len;
    logic              i_abort;
    logic              o_ready;
    logic              o_mac_clr;
    logic              o_rd_en;
    logic [ADDR_W-1:0] o_addr;
    logic              o_acc;
    logic [WIDTH-1:0]  mac_q;
    logic [WIDTH-1:0]  o_result;
    logic              o_valid;
    logic              i_out_ready;

    logic [WIDTH-1:0]  xram [0:(1<<ADDR_W)-1];
    logic [WIDTH-1:0]  mram [0:(1<<ADDR_W)-1];
    logic [WIDTH-1:0]  x_rd, m_rd;
    logic signed [2*WIDTH-1:0] prod;
    logic              mac_load;
    logic [WIDTH-1:0]  mac_preload;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [ADDR_W-1:0] base;
        logic [LEN_W-1:0]  len;
        logic [WIDTH-1:0]  exp;
        int                hold;
        bit                preload;
    } vec_t;

    vec_t vecs [7];

    mac_seq #(.WIDTH(WIDTH), .LEN_W(LEN_W), .ADDR_W(ADDR_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_start     (i_start),
        .i_base      (i_base),
        .i_len       (i_len),
        .i_abort     (i_abort),
        .o_ready     (o_ready),
        .o_mac_clr   (o_mac_clr),
        .o_rd_en     (o_rd_en),
        .o_addr      (o_addr),
        .o_acc       (o_acc),
        .i_mac       (mac_q),
        .o_result    (o_result),
        .o_valid     (o_valid),
        .i_out_ready (i_out_ready)
    );

    always #5 clk = ~clk;

    // Operand RAMs with one cycle of read latency.
    always @(posedge clk) begin
        if (o_rd_en) begin
            x_rd <= xram[o_addr];
            m_rd <= mram[o_addr];
        end
    end

    assign prod = $signed(x_rd) * $signed(m_rd);

    // Reference mac: synchronous clear, accumulate Q.FRAC products while acc is high.
    always @(posedge clk) begin
        if (mac_load)       mac_q <= mac_preload;
        else if (o_mac_clr) mac_q <= '0;
        else if (o_acc)     mac_q <= mac_q + prod[FRAC+WIDTH-1:FRAC];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
        end
    endtask

    task automatic run_job(input logic [ADDR_W-1:0] b, input logic [LEN_W-1:0] l,
                           input logic [WIDTH-1:0] exp, input int hold, input string nm);
        int cyc = 0, acc_n = 0, rd_n = 0, clr_n = 0, addr_bad = 0, bad = 0;
        logic [ADDR_W-1:0] ea;
        int exp_lat;
        exp_lat = (l == 0) ? 3 : int'(l) + 4;
        @(negedge clk);
        chk({nm, "_ready"}, 32'(o_ready), 32'd1);
        i_start = 1'b1;
        i_base  = b;
        i_len   = l;
        @(posedge clk);
        cyc = 1;
        #1;
        i_start = 1'b0;
        while (!o_valid && cyc < 400) begin
            if (o_acc)     acc_n++;
            if (o_mac_clr) clr_n++;
            if (o_rd_en) begin
                ea = b + ADDR_W'(rd_n);
                if (o_addr !== ea) addr_bad++;
                rd_n++;
            end
            @(posedge clk);
            cyc++;
            #1;
        end
        chk({nm, "_latency"}, 32'(cyc), 32'(exp_lat));
        chk({nm, "_acc_cycles"}, 32'(acc_n), 32'(l));
        chk({nm, "_rd_cycles"}, 32'(rd_n), 32'(l));
        chk({nm, "_clr_pulses"}, 32'(clr_n), 32'd1);
        chk({nm, "_addr_seq"}, 32'(addr_bad), 32'd0);
        chk({nm, "_result"}, 32'(o_result), 32'(exp));
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            i_start = 1'b1;
            i_base  = 10'd5;
            i_len   = 8'd6;
            @(posedge clk);
            #1;
            if (o_valid !== 1'b1 || o_result !== exp || o_ready !== 1'b0) bad++;
        end
        i_start = 1'b0;
        if (hold > 0) chk({nm, "_hold_stable"}, 32'(bad), 32'd0);
        @(negedge clk);
        i_out_ready = 1'b1;
        @(posedge clk);
        #1;
        i_out_ready = 1'b0;
        chk({nm, "_released"}, {30'd0, o_valid, o_ready}, 32'b01);
    endtask

    initial begin
        int seen, found;
        rst = 1'b0; i_start = 1'b0; i_base = '0; i_len = '0; i_abort = 1'b0;
        i_out_ready = 1'b0; mac_load = 1'b0; mac_preload = '0;
        for (int a = 0; a < (1 << ADDR_W); a++) begin
            xram[a] = '0;
            mram[a] = '0;
        end
        xram[0] = 24'h100000; xram[1] = 24'h200000; xram[2] = 24'h080000; xram[3] = 24'hF00000;
        for (int a = 0; a < 4; a++) mram[a] = 24'h100000;
        xram[8] = 24'h100000; xram[9] = 24'h200000; mram[8] = 24'h100000; mram[9] = 24'h100000;
        xram[1022] = 24'h040000; mram[1022] = 24'h200000;
        xram[1023] = 24'h080000; mram[1023] = 24'h200000;
        for (int a = 0; a < 4; a++) begin
            xram[16+a] = 24'(a + 1) << FRAC;
            mram[16+a] = 24'h080000;
        end
        xram[24] = 24'hE00000; mram[24] = 24'h180000;
        xram[25] = 24'h080000; mram[25] = 24'hF00000;

        vecs[0] = '{base: 10'd0,    len: 8'd4, exp: 24'h280000, hold: 0,  preload: 1'b0};
        vecs[1] = '{base: 10'd0,    len: 8'd0, exp: 24'h000000, hold: 0,  preload: 1'b1};
        vecs[2] = '{base: 10'd8,    len: 8'd2, exp: 24'h300000, hold: 0,  preload: 1'b0};
        vecs[3] = '{base: 10'd8,    len: 8'd1, exp: 24'h100000, hold: 0,  preload: 1'b0};
        vecs[4] = '{base: 10'd1022, len: 8'd3, exp: 24'h280000, hold: 10, preload: 1'b0};
        vecs[5] = '{base: 10'd16,   len: 8'd4, exp: 24'h500000, hold: 0,  preload: 1'b0};
        vecs[6] = '{base: 10'd24,   len: 8'd2, exp: 24'hC80000, hold: 0,  preload: 1'b0};

        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {o_ready, o_mac_clr, o_rd_en, o_acc, o_valid, 17'd0, o_addr},
            {5'b11000, 27'd0});
        chk("reset_result", 32'(o_result), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        for (int v = 0; v < 7; v++) begin
            if (vecs[v].preload) begin
                @(negedge clk);
                mac_load = 1'b1;
                mac_preload = 24'h123456;
                @(negedge clk);
                mac_load = 1'b0;
            end
            run_job(vecs[v].base, vecs[v].len, vecs[v].exp, vecs[v].hold, $sformatf("vec%0d", v));
        end

        // Abort at RUN k=2 of a length-8 job.
        @(negedge clk);
        i_start = 1'b1; i_base = 10'd0; i_len = 8'd8;
        @(posedge clk);
        #1;
        i_start = 1'b0;
        found = 0;
        for (int c = 0; c < 20 && found == 0; c++) begin
            if (o_rd_en && o_addr == 10'd2) found = 1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        chk("abort_reached_k2", 32'(found), 32'd1);
        i_abort = 1'b1;
        @(posedge clk);
        #1;
        i_abort = 1'b0;
        chk("abort_next_cycle", {28'd0, o_ready, o_rd_en, o_acc, o_valid}, 32'b1000);
        seen = 0;
        for (int c = 0; c < 15; c++) begin
            @(posedge clk);
            #1;
            if (o_valid) seen++;
        end
        chk("abort_no_valid", 32'(seen), 32'd0);
        chk("abort_result_kept", 32'(o_result), 32'hC80000);

        // Abort together with start in IDLE: start is refused.
        @(negedge clk);
        i_start = 1'b1; i_abort = 1'b1; i_base = 10'd0; i_len = 8'd2;
        @(posedge clk);
        #1;
        i_start = 1'b0; i_abort = 1'b0;
        chk("abort_beats_start", {30'd0, o_ready, o_mac_clr}, 32'b10);

        // Asynchronous reset in the middle of a run, then a fresh job.
        @(negedge clk);
        i_start = 1'b1; i_base = 10'd0; i_len = 8'd4;
        @(posedge clk);
        #1;
        i_start = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk("midrun_reset_outputs", {o_ready, o_mac_clr, o_rd_en, o_acc, o_valid, 17'd0, o_addr},
            {5'b11000, 27'd0});
        chk("midrun_reset_result", 32'(o_result), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        run_job(10'd0, 8'd4, 24'h280000, 0, "after_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
